// File: rtl/inst_fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational ROM,
// buffers up to two instructions for decode, and handles redirects and fetch faults.
module inst_fetch_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 32,
  parameter int RESET_PC    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_q,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_fault,
  output logic [15:0]           o_fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH    = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LP_RESET_PC = ADDR_WIDTH'(RESET_PC);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_instr0, r_instr1, w_instr0_nxt, w_instr1_nxt;
  logic [ADDR_WIDTH-1:0] r_pc0, r_pc1, w_pc0_nxt, w_pc1_nxt;
  logic                  r_fault, w_fault_nxt;
  logic [15:0]           r_fcnt, w_fcnt_nxt;
  logic                  w_pop, w_push, w_space, w_legal, w_redir_ok;

  assign w_legal    = (r_fetch_pc >> 2) < LP_DEPTH;
  assign w_redir_ok = (i_redirect_pc[1:0] == 2'b00) && ((i_redirect_pc >> 2) < LP_DEPTH);
  assign w_pop      = (r_cnt != 2'd0) && i_instr_ready;
  // A full buffer still has room when the head leaves this cycle.
  assign w_space    = (r_cnt < 2'd2) || w_pop;
  assign w_push     = (r_state == S_RUN) && !i_redirect_valid && w_legal && w_space;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_cnt_nxt      = r_cnt;
    w_instr0_nxt   = r_instr0;
    w_instr1_nxt   = r_instr1;
    w_pc0_nxt      = r_pc0;
    w_pc1_nxt      = r_pc1;
    w_fault_nxt    = r_fault;
    w_fcnt_nxt     = r_fcnt;
    if (i_redirect_valid) begin
      w_cnt_nxt      = 2'd0;
      w_fetch_pc_nxt = i_redirect_pc;
      if (w_redir_ok) begin
        w_fault_nxt = 1'b0;
        w_state_nxt = S_RUN;
      end else begin
        w_fault_nxt = 1'b1;
        w_state_nxt = S_FAULT;
      end
    end else begin
      case (r_state)
        S_BOOT:  w_state_nxt = S_RUN;
        S_RUN: begin
          if (!w_legal) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_FAULT;
          end
        end
        default: w_state_nxt = r_state;
      endcase
      if (w_push) begin
        w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);
        w_fcnt_nxt     = r_fcnt + 16'd1;
      end
      // Slot 0 is always the head; slot 1 only matters when two entries are held.
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            w_instr0_nxt = i_mem_q;
            w_pc0_nxt    = r_fetch_pc;
          end else begin
            w_instr1_nxt = i_mem_q;
            w_pc1_nxt    = r_fetch_pc;
          end
          w_cnt_nxt = r_cnt + 2'd1;
        end
        2'b01: begin
          w_instr0_nxt = r_instr1;
          w_pc0_nxt    = r_pc1;
          w_cnt_nxt    = r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            w_instr0_nxt = i_mem_q;
            w_pc0_nxt    = r_fetch_pc;
          end else begin
            w_instr0_nxt = r_instr1;
            w_pc0_nxt    = r_pc1;
            w_instr1_nxt = i_mem_q;
            w_pc1_nxt    = r_fetch_pc;
          end
        end
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= LP_RESET_PC;
      r_cnt      <= 2'd0;
      r_instr0   <= '0;
      r_instr1   <= '0;
      r_pc0      <= '0;
      r_pc1      <= '0;
      r_fault    <= 1'b0;
      r_fcnt     <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_instr0   <= w_instr0_nxt;
      r_instr1   <= w_instr1_nxt;
      r_pc0      <= w_pc0_nxt;
      r_pc1      <= w_pc1_nxt;
      r_fault    <= w_fault_nxt;
      r_fcnt     <= w_fcnt_nxt;
    end
  end

  assign o_mem_addr    = r_fetch_pc >> 2;
  assign o_instr       = r_instr0;
  assign o_instr_pc    = r_pc0;
  assign o_instr_valid = (r_cnt != 2'd0);
  assign o_fault       = r_fault;
  assign o_fetch_count = r_fcnt;

endmodule
